// File: rtl/uart_pkg.sv
// uart_pkg: parity codes, frame FSM encoding and reset-default receiver config
package uart_pkg;
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_CAPTURE} frame_state_t;
   typedef struct packed {
      logic       d_num;
      logic       s_num;
      logic [1:0] par;
   } rx_cfg_t;
   localparam rx_cfg_t CFG_DEFAULT = '{d_num: 1'b1, s_num: 1'b1, par: PAR_NONE};
   function automatic logic par_enabled(input logic [1:0] par);
      return par == PAR_ODD || par == PAR_EVEN;
   endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 9-bit FIFO with separate count; a pop frees room for a same-cycle push when full
module uart_rx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [8:0]               wdata,
   input  logic                     pop,
   output logic [8:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;
   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wdata;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
         count  <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: owns the UART receiver config and queues each completed frame for the host
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int IDLE_GAP = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_line,
   input  logic                   rx_avail,
   input  logic [7:0]             rx_data,
   input  logic                   rx_perr,
   output logic                   rx_rst_n,
   output logic                   rx_d_num,
   output logic                   rx_s_num,
   output logic [1:0]             rx_par,
   input  logic                   cfg_wr,
   input  logic                   cfg_d_num,
   input  logic                   cfg_s_num,
   input  logic [1:0]             cfg_par,
   output logic                   cfg_pending,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_data,
   output logic                   out_perr,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   ovf,
   input  logic                   ovf_clr
);
   localparam int GW = $clog2(IDLE_GAP + 1);
   frame_state_t  state;
   logic [GW-1:0] gap;
   rx_cfg_t       shadow, active;
   logic          push, pop, full, empty, gap_qual, apply;
   assign rx_rst_n  = ~rst;
   assign rx_d_num  = active.d_num;
   assign rx_s_num  = active.s_num;
   assign rx_par    = active.par;
   assign push      = state == ST_CAPTURE;
   assign pop       = out_valid && out_ready;
   assign out_valid = !empty;
   assign gap_qual  = state == ST_IDLE && rx_avail && rx_line;
   assign apply     = cfg_pending && gap == GW'(IDLE_GAP);
   // Capture is one cycle after available rises, once the receiver has updated its buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         gap         <= '0;
         shadow      <= CFG_DEFAULT;
         active      <= CFG_DEFAULT;
         cfg_pending <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         state       <= state == ST_IDLE ? (rx_avail ? ST_IDLE : ST_BUSY) :
                        state == ST_BUSY ? (rx_avail ? ST_CAPTURE : ST_BUSY) : ST_IDLE;
         gap         <= !gap_qual ? '0 : gap == GW'(IDLE_GAP) ? gap : gap + GW'(1);
         active      <= apply ? shadow : active;
         shadow      <= cfg_wr ? '{d_num: cfg_d_num, s_num: cfg_s_num, par: cfg_par} : shadow;
         cfg_pending <= cfg_wr || (cfg_pending && !apply);
         ovf         <= (push && full && !pop) || (ovf && !ovf_clr);
      end
   end
   uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({rx_data, rx_perr && par_enabled(active.par)}),
      .pop   (pop),
      .rdata ({out_data, out_perr}),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized frames checked against a queue-based model of the controller
module tb_uart_rx_ctrl;
   localparam int DEPTH = 4;
   logic       clk = 1'b0;
   logic       rst, rx_line, rx_avail, rx_perr, cfg_wr, cfg_d_num, cfg_s_num, out_ready, ovf_clr;
   logic [7:0] rx_data;
   logic [1:0] cfg_par;
   logic       rx_rst_n, rx_d_num, rx_s_num, cfg_pending, out_valid, out_perr, ovf;
   logic [1:0] rx_par;
   logic [7:0] out_data;
   logic [2:0] fifo_count;
   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q[$];
   logic       ovf_m;
   logic [3:0] act_cfg;

   uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_GAP(16)) dut (
      .clk(clk), .rst(rst), .rx_line(rx_line), .rx_avail(rx_avail), .rx_data(rx_data),
      .rx_perr(rx_perr), .rx_rst_n(rx_rst_n), .rx_d_num(rx_d_num), .rx_s_num(rx_s_num),
      .rx_par(rx_par), .cfg_wr(cfg_wr), .cfg_d_num(cfg_d_num), .cfg_s_num(cfg_s_num),
      .cfg_par(cfg_par), .cfg_pending(cfg_pending), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_perr(out_perr),
      .fifo_count(fifo_count), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic model_perr(input logic pe);
      return pe && (act_cfg[1:0] == 2'b01 || act_cfg[1:0] == 2'b10);
   endfunction

   task automatic pop_one;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      void'(exp_q.pop_front());
   endtask

   task automatic set_cfg(input logic d, input logic s, input logic [1:0] p);
      cfg_wr = 1'b1; cfg_d_num = d; cfg_s_num = s; cfg_par = p;
      tick();
      cfg_wr = 1'b0;
      for (int i = 0; i < 40 && cfg_pending; i++) tick();
      act_cfg = {d, s, p};
   endtask

   // One frame: line busy with available low, then available rises and the byte appears a cycle later
   task automatic send_frame(input logic [7:0] d, input logic pe, input bit pop_cap, input bit clr_cap);
      int n = $urandom_range(3, 40);
      rx_data = 8'($urandom);
      rx_perr = 1'($urandom);
      rx_avail = 1'b0;
      repeat (n) begin
         rx_line = 1'($urandom);
         tick();
      end
      rx_avail = 1'b1; rx_line = 1'b1;
      tick();
      rx_data = d; rx_perr = pe; out_ready = pop_cap; ovf_clr = clr_cap;
      tick();
      out_ready = 1'b0; ovf_clr = 1'b0; rx_data = 8'($urandom); rx_perr = 1'($urandom);
      if (clr_cap) ovf_m = 1'b0;
      if (pop_cap && exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() < DEPTH) exp_q.push_back({d, model_perr(pe)});
      else ovf_m = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      checks++;
      if (rx_rst_n !== 1'b0) begin errors++; $display("FAIL reset_rx_rst_n got %b exp 0", rx_rst_n); end
      rst = 1'b0;
      #1;
      checks++;
      if (rx_rst_n !== 1'b1) begin errors++; $display("FAIL release_rx_rst_n got %b exp 1", rx_rst_n); end
      checks++;
      if ({out_valid, fifo_count, ovf, cfg_pending, rx_d_num, rx_s_num, rx_par, out_data, out_perr} !==
          {1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_values got v=%b c=%0d o=%b p=%b d=%b s=%b par=%b data=%h perr=%b",
                  out_valid, fifo_count, ovf, cfg_pending, rx_d_num, rx_s_num, rx_par, out_data, out_perr);
      end
      exp_q.delete(); ovf_m = 1'b0; act_cfg = 4'b1100;
   endtask

   task automatic test_basic;
      rx_data = 8'($urandom); rx_avail = 1'b0;
      repeat ($urandom_range(5, 30)) begin rx_line = 1'($urandom); tick(); end
      rx_avail = 1'b1; rx_line = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
      rx_data = 8'hA5; rx_perr = 1'b0;
      tick();
      checks++;
      if ({out_valid, out_data, out_perr, fifo_count} !== {1'b1, 8'hA5, 1'b0, 3'd1}) begin
         errors++;
         $display("FAIL basic_capture got v=%b d=%h p=%b c=%0d exp v=1 d=a5 p=0 c=1", out_valid, out_data, out_perr, fifo_count);
      end
      exp_q.push_back({8'hA5, 1'b0});
      pop_one();
      checks++;
      if ({out_valid, fifo_count} !== {1'b0, 3'd0}) begin
         errors++; $display("FAIL basic_pop got v=%b c=%0d exp v=0 c=0", out_valid, fifo_count);
      end
   endtask

   task automatic test_parity;
      for (int p = 0; p < 4; p++) begin
         set_cfg(1'b0, 1'b1, 2'(p));
         checks++;
         if ({cfg_pending, rx_d_num, rx_s_num, rx_par} !== {1'b0, act_cfg}) begin
            errors++; $display("FAIL parity_cfg got pend=%b cfg=%b exp pend=0 cfg=%b", cfg_pending, {rx_d_num, rx_s_num, rx_par}, act_cfg);
         end
         send_frame(8'h41, 1'b1, 1'b0, 1'b0);
         for (int k = 0; k < 2; k++) send_frame(8'($urandom), 1'($urandom), 1'b0, 1'b0);
         while (exp_q.size() > 0) begin
            checks++;
            if ({out_valid, out_data, out_perr} !== {1'b1, exp_q[0]}) begin
               errors++; $display("FAIL parity_entry par=%0d got v=%b d=%h p=%b exp d=%h p=%b", p, out_valid, out_data, out_perr, exp_q[0][8:1], exp_q[0][0]);
            end
            pop_one();
         end
      end
   endtask

   task automatic test_cfg_midframe;
      logic [3:0] old_cfg, tgt, third;
      set_cfg(1'b1, 1'b1, 2'b00);
      old_cfg = act_cfg; tgt = 4'b0010; third = 4'b1101;
      rx_avail = 1'b0;
      repeat (10) begin rx_line = 1'($urandom); tick(); end
      cfg_wr = 1'b1; {cfg_d_num, cfg_s_num, cfg_par} = 4'($urandom);
      tick();
      {cfg_d_num, cfg_s_num, cfg_par} = tgt;
      tick();
      cfg_wr = 1'b0;
      repeat (30) begin rx_line = 1'($urandom); tick(); end
      checks++;
      if ({cfg_pending, rx_d_num, rx_s_num, rx_par} !== {1'b1, old_cfg}) begin
         errors++; $display("FAIL midframe_hold got pend=%b cfg=%b exp pend=1 cfg=%b", cfg_pending, {rx_d_num, rx_s_num, rx_par}, old_cfg);
      end
      rx_avail = 1'b1; rx_line = 1'b1;
      tick();
      rx_data = 8'($urandom); rx_perr = 1'b0;
      exp_q.push_back({rx_data, 1'b0});
      tick();
      for (int i = 0; i < 17; i++) begin
         checks++;
         if ({cfg_pending, rx_d_num, rx_s_num, rx_par} !== {1'b1, old_cfg}) begin
            errors++; $display("FAIL gap_hold cycle=%0d got pend=%b cfg=%b exp pend=1 cfg=%b", i, cfg_pending, {rx_d_num, rx_s_num, rx_par}, old_cfg);
         end
         if (i < 16) tick();
      end
      cfg_wr = 1'b1; {cfg_d_num, cfg_s_num, cfg_par} = third;
      tick();
      cfg_wr = 1'b0;
      checks++;
      if ({cfg_pending, rx_d_num, rx_s_num, rx_par} !== {1'b1, tgt}) begin
         errors++; $display("FAIL apply_with_write got pend=%b cfg=%b exp pend=1 cfg=%b", cfg_pending, {rx_d_num, rx_s_num, rx_par}, tgt);
      end
      for (int i = 0; i < 40 && cfg_pending; i++) tick();
      act_cfg = third;
      checks++;
      if ({cfg_pending, rx_d_num, rx_s_num, rx_par} !== {1'b0, third}) begin
         errors++; $display("FAIL second_apply got pend=%b cfg=%b exp pend=0 cfg=%b", cfg_pending, {rx_d_num, rx_s_num, rx_par}, third);
      end
      checks++;
      if ({out_valid, out_data} !== {1'b1, exp_q[0][8:1]}) begin
         errors++; $display("FAIL midframe_data got v=%b d=%h exp d=%h", out_valid, out_data, exp_q[0][8:1]);
      end
      pop_one();
   endtask

   task automatic test_overflow;
      logic [8:0] head;
      for (int i = 0; i < 5; i++) begin
         send_frame(8'($urandom), 1'($urandom), 1'b0, 1'b0);
         checks++;
         if ({fifo_count, ovf} !== {3'(exp_q.size()), ovf_m}) begin
            errors++; $display("FAIL ovf_fill frame=%0d got c=%0d o=%b exp c=%0d o=%b", i, fifo_count, ovf, exp_q.size(), ovf_m);
         end
      end
      head = exp_q[0];
      repeat (3) begin
         tick();
         checks++;
         if ({out_data, out_perr} !== head) begin
            errors++; $display("FAIL hold_stable got %h exp %h", {out_data, out_perr}, head);
         end
      end
      while (exp_q.size() > 0) begin
         checks++;
         if ({out_valid, out_data, out_perr} !== {1'b1, exp_q[0]}) begin
            errors++; $display("FAIL ovf_entry got v=%b d=%h p=%b exp d=%h p=%b", out_valid, out_data, out_perr, exp_q[0][8:1], exp_q[0][0]);
         end
         pop_one();
      end
      checks++;
      if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0; ovf_m = 1'b0;
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
      for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'($urandom), 1'b0, 1'b0);
      send_frame(8'($urandom), 1'($urandom), 1'b0, 1'b1);
      checks++;
      if ({fifo_count, ovf} !== {3'd4, ovf_m}) begin
         errors++; $display("FAIL clr_vs_ovf got c=%0d o=%b exp c=4 o=%b", fifo_count, ovf, ovf_m);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0; ovf_m = 1'b0;
   endtask

   task automatic test_full_pushpop;
      checks++;
      if ({fifo_count, out_data, out_perr} !== {3'd4, exp_q[0]}) begin
         errors++; $display("FAIL full_head got c=%0d h=%h exp c=4 h=%h", fifo_count, {out_data, out_perr}, exp_q[0]);
      end
      send_frame(8'($urandom), 1'($urandom), 1'b1, 1'b0);
      checks++;
      if ({fifo_count, ovf, out_data, out_perr} !== {3'd4, 1'b0, exp_q[0]}) begin
         errors++; $display("FAIL full_pushpop got c=%0d o=%b h=%h exp c=4 o=0 h=%h", fifo_count, ovf, {out_data, out_perr}, exp_q[0]);
      end
      while (exp_q.size() > 0) begin
         checks++;
         if ({out_valid, out_data, out_perr} !== {1'b1, exp_q[0]}) begin
            errors++; $display("FAIL pushpop_entry got v=%b d=%h p=%b exp d=%h p=%b", out_valid, out_data, out_perr, exp_q[0][8:1], exp_q[0][0]);
         end
         pop_one();
      end
   endtask

   task automatic test_rst_midframe;
      set_cfg(1'b0, 1'b1, 2'b01);
      send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
      send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
      rx_avail = 1'b0;
      cfg_wr = 1'b1; {cfg_d_num, cfg_s_num, cfg_par} = 4'b0010;
      tick();
      cfg_wr = 1'b0;
      repeat (80) begin rx_line = 1'($urandom); tick(); end
      rst = 1'b1; rx_avail = 1'b1; rx_line = 1'b1;
      tick();
      checks++;
      if ({rx_rst_n, out_valid, fifo_count, ovf, cfg_pending, rx_d_num, rx_s_num, rx_par, out_data, out_perr} !==
          {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL midframe_rst got n=%b v=%b c=%0d o=%b p=%b cfg=%b d=%h e=%b", rx_rst_n, out_valid, fifo_count, ovf,
                  cfg_pending, {rx_d_num, rx_s_num, rx_par}, out_data, out_perr);
      end
      rst = 1'b0;
      exp_q.delete(); ovf_m = 1'b0; act_cfg = 4'b1100;
      tick();
      send_frame(8'($urandom), 1'($urandom), 1'b0, 1'b0);
      checks++;
      if ({fifo_count, out_valid, out_data, out_perr} !== {3'd1, 1'b1, exp_q[0]}) begin
         errors++; $display("FAIL post_rst_frame got c=%0d v=%b h=%h exp c=1 h=%h", fifo_count, out_valid, {out_data, out_perr}, exp_q[0]);
      end
      pop_one();
   endtask

   task automatic test_back_to_back;
      for (int f = 0; f < 30; f++) begin
         if (f % 10 == 5) begin
            set_cfg(1'($urandom), 1'($urandom), 2'($urandom));
            checks++;
            if ({rx_d_num, rx_s_num, rx_par} !== act_cfg) begin
               errors++; $display("FAIL rand_cfg got %b exp %b", {rx_d_num, rx_s_num, rx_par}, act_cfg);
            end
         end
         while (exp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            checks++;
            if ({out_valid, out_data, out_perr} !== {1'b1, exp_q[0]}) begin
               errors++; $display("FAIL rand_entry got v=%b d=%h p=%b exp d=%h p=%b", out_valid, out_data, out_perr, exp_q[0][8:1], exp_q[0][0]);
            end
            pop_one();
         end
         send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
         checks++;
         if ({fifo_count, ovf} !== {3'(exp_q.size()), ovf_m}) begin
            errors++; $display("FAIL rand_state frame=%0d got c=%0d o=%b exp c=%0d o=%b", f, fifo_count, ovf, exp_q.size(), ovf_m);
         end
      end
      while (exp_q.size() > 0) begin
         checks++;
         if ({out_valid, out_data, out_perr} !== {1'b1, exp_q[0]}) begin
            errors++; $display("FAIL rand_drain got v=%b d=%h p=%b exp d=%h p=%b", out_valid, out_data, out_perr, exp_q[0][8:1], exp_q[0][0]);
         end
         pop_one();
      end
   endtask

   initial begin
      rst = 1'b1; rx_line = 1'b1; rx_avail = 1'b1; rx_perr = 1'b0; rx_data = 8'h00;
      cfg_wr = 1'b0; cfg_d_num = 1'b1; cfg_s_num = 1'b1; cfg_par = 2'b00;
      out_ready = 1'b0; ovf_clr = 1'b0; ovf_m = 1'b0; act_cfg = 4'b1100;
      tick();
      test_reset();
      test_basic();
      test_parity();
      test_cfg_midframe();
      test_overflow();
      test_full_pushpop();
      test_rst_midframe();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
